instr_reg_arbiter: RTL

Controller that sits in front of the 32-entry instruction register and shares its write port between two requesters with round-robin arbitration. It owns the register's `reset_n`, `load_en`, `write_pointer` and `read_pointer`. It sequences the register's reset hold, auto-allocates write addresses and tracks which entries hold valid data. It also serves a single read-request port, returning the stored instruction word with a hit flag.

---
 rtl/instr_register_pkg.sv | 14 +
 rtl/instr_reg_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_register_pkg.sv
// Types shared between the instruction register and the blocks that drive it.
package instr_register_pkg;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_reg_arbiter.sv
// Front-end controller for the 32-entry instruction register: reset sequencing,
// round-robin sharing of the write port, address allocation and a read port.
module instr_reg_arbiter
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PTR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  opcode_t            req_opcode0,
  input  opcode_t            req_opcode1,
  input  operand_t           req_op_a0,
  input  operand_t           req_op_a1,
  input  operand_t           req_op_b0,
  input  operand_t           req_op_b1,
  output logic [PTR_W-1:0]   wr_addr,
  input  logic               rd_req,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic               rd_ready,
  output logic               rd_valid,
  output instruction_t       rd_word,
  output logic               rd_hit,
  output logic [PTR_W:0]     count,
  output logic               full,
  output logic               reg_reset_n,
  output logic               load_en,
  output logic [PTR_W-1:0]   write_pointer,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output logic [PTR_W-1:0]   read_pointer,
  input  instruction_t       instruction_word
);

  localparam int unsigned HOLD_CYCLES = 2;
  localparam int unsigned HOLD_W      = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
  logic               prio;
  logic [PTR_W-1:0]   alloc_ptr;
  logic [DEPTH-1:0]   valid_map;
  logic               rd_pend;
  logic               rd_pend_hit;
  logic [1:0]         xfer;
  logic               any_xfer;
  logic               rd_accept;

  assign xfer      = req_valid & req_ready;
  assign any_xfer  = |xfer;
  assign rd_accept = rd_req && rd_ready;
  assign wr_addr   = alloc_ptr;
  assign full      = (count == (PTR_W+1)'(DEPTH));

  // State register; reset and clear both restart the hold sequence.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= INIT;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // RUN is entered one cycle before reg_reset_n rises, so the first accepted
  // write is loaded just after the register leaves reset.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    req_ready     = 2'b00;
    rd_ready      = 1'b0;
    case (state)
      INIT: begin
        hold_cnt_next = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 2)) state_next = RUN;
      end
      RUN: begin
        if (!full) begin
          req_ready[0] = !req_valid[1] || !prio;
          req_ready[1] = !req_valid[0] || prio;
        end
        rd_ready = !(load_en && (rd_addr == write_pointer));
      end
      default: state_next = INIT;
    endcase
  end

  // Write port, allocation, occupancy and read pipeline control.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      reg_reset_n   <= 1'b0;
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      prio          <= 1'b0;
      alloc_ptr     <= '0;
      valid_map     <= '0;
      count         <= '0;
      rd_pend       <= 1'b0;
      rd_pend_hit   <= 1'b0;
      rd_valid      <= 1'b0;
      rd_hit        <= 1'b0;
    end else begin
      reg_reset_n <= (state == RUN);
      load_en     <= any_xfer;
      if (any_xfer) begin
        write_pointer        <= alloc_ptr;
        opcode               <= xfer[1] ? req_opcode1 : req_opcode0;
        operand_a            <= xfer[1] ? req_op_a1 : req_op_a0;
        operand_b            <= xfer[1] ? req_op_b1 : req_op_b0;
        alloc_ptr            <= alloc_ptr + PTR_W'(1);
        valid_map[alloc_ptr] <= 1'b1;
        count                <= count + (PTR_W+1)'(1);
        prio                 <= ~xfer[1];
      end
      rd_pend  <= rd_accept;
      rd_valid <= rd_pend;
      if (rd_accept) rd_pend_hit <= valid_map[rd_addr];
      if (rd_pend)   rd_hit      <= rd_pend_hit;
    end
  end

  // Read address and captured word survive clear; only reset returns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer <= {PTR_W{1'b1}};
      rd_word      <= '0;
    end else if (!clear) begin
      if (rd_accept) read_pointer <= rd_addr;
      if (rd_pend)   rd_word      <= instruction_word;
    end
  end

endmodule
